// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int CNT_W                 = 6;
  localparam int DEF_DIV_LATENCY       = 33;
  localparam int DEF_TRAP_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIV_BUSY   = 2'd1,
    ST_TRAP_FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute status in, stall/flush/divider controls out.
interface hazard_ctrl_if;

  logic       if_en;
  logic       rs0_used;
  logic       rs1_used;
  logic [4:0] gpr_rd_addr_0;
  logic [4:0] gpr_rd_addr_1;
  logic       load_in_id_ex;
  logic [4:0] id_dst_addr;
  logic       id_is_div;
  logic       rem_after_div;
  logic       branch_taken;
  logic       trap_req;

  logic       if_stall;
  logic       id_stall;
  logic       if_flush;
  logic       id_flush;
  logic       div_start;
  logic       div_done;
  logic       div_abort;
  logic       div_busy;

  modport master (
    output if_en, rs0_used, rs1_used, gpr_rd_addr_0, gpr_rd_addr_1,
           load_in_id_ex, id_dst_addr, id_is_div, rem_after_div,
           branch_taken, trap_req,
    input  if_stall, id_stall, if_flush, id_flush,
           div_start, div_done, div_abort, div_busy
  );

  modport slave (
    input  if_en, rs0_used, rs1_used, gpr_rd_addr_0, gpr_rd_addr_1,
           load_in_id_ex, id_dst_addr, id_is_div, rem_after_div,
           branch_taken, trap_req,
    output if_stall, id_stall, if_flush, id_flush,
           div_start, div_done, div_abort, div_busy
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: trap/branch flushes, multi-cycle divide stall, load-use bubble.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY       = DEF_DIV_LATENCY,
  parameter int TRAP_FLUSH_CYCLES = DEF_TRAP_FLUSH_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_en,
  hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 2);
  localparam logic [CNT_W-1:0] TRAP_LOAD = CNT_W'(TRAP_FLUSH_CYCLES - 1);

  hz_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic load_use;
  logic if_stall, id_stall, if_flush, id_flush;
  logic div_start, div_done, div_abort, div_busy;

  assign load_use = hz.load_in_id_ex && hz.if_en && (hz.id_dst_addr != 5'd0) &&
                    ((hz.rs0_used && (hz.gpr_rd_addr_0 == hz.id_dst_addr)) ||
                     (hz.rs1_used && (hz.gpr_rd_addr_1 == hz.id_dst_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (cpu_en) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    div_start = 1'b0;
    div_done  = 1'b0;
    div_abort = 1'b0;
    div_busy  = (state == ST_DIV_BUSY);

    // A trap overrides everything, including an in-flight divide.
    if (hz.trap_req) begin
      if_flush  = 1'b1;
      id_flush  = 1'b1;
      div_abort = (state == ST_DIV_BUSY);
      cnt_n     = TRAP_LOAD;
      state_n   = ST_TRAP_FLUSH;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hz.branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (hz.id_is_div && !hz.rem_after_div) begin
            div_start = 1'b1;
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            cnt_n     = DIV_LOAD;
            state_n   = ST_DIV_BUSY;
          end else if (load_use) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
          end
        end
        ST_DIV_BUSY: begin
          if (cnt != '0) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            cnt_n    = cnt - 1'b1;
          end else begin
            div_done = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        ST_TRAP_FLUSH: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          if (cnt == '0) state_n = ST_IDLE;
          else           cnt_n   = cnt - 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign hz.if_stall  = if_stall;
  assign hz.id_stall  = id_stall;
  assign hz.if_flush  = if_flush;
  assign hz.id_flush  = id_flush;
  assign hz.div_start = div_start;
  assign hz.div_done  = div_done;
  assign hz.div_abort = div_abort;
  assign hz.div_busy  = div_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle expected output vectors queued and compared.
module tb_hazard_ctrl;

  localparam logic [7:0] S_IF  = 8'h80;
  localparam logic [7:0] S_ID  = 8'h40;
  localparam logic [7:0] F_IF  = 8'h20;
  localparam logic [7:0] F_ID  = 8'h10;
  localparam logic [7:0] START = 8'h08;
  localparam logic [7:0] DONE  = 8'h04;
  localparam logic [7:0] ABORT = 8'h02;
  localparam logic [7:0] BUSY  = 8'h01;
  localparam logic [7:0] STALL = S_IF | S_ID;
  localparam logic [7:0] FLUSH = F_IF | F_ID;

  typedef struct {
    string      tag;
    int         cyc;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_en;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t ex;
  logic [7:0] obs;

  hazard_ctrl_if hif();

  hazard_ctrl u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cpu_en (cpu_en),
    .hz     (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {hif.if_stall, hif.id_stall, hif.if_flush, hif.id_flush,
            hif.div_start, hif.div_done, hif.div_abort, hif.div_busy};
  endfunction

  task automatic clear_in();
    hif.if_en = 1'b0; hif.rs0_used = 1'b0; hif.rs1_used = 1'b0;
    hif.gpr_rd_addr_0 = 5'd0; hif.gpr_rd_addr_1 = 5'd0;
    hif.load_in_id_ex = 1'b0; hif.id_dst_addr = 5'd0;
    hif.id_is_div = 1'b0; hif.rem_after_div = 1'b0;
    hif.branch_taken = 1'b0; hif.trap_req = 1'b0;
    cpu_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    sb.push_back('{"reset", 0, 8'h00});
    @(negedge clk);
    obs = outs(); ex = sb.pop_front(); checks++;
    if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{"idle", 0, 8'h00});
    @(negedge clk);
    obs = outs(); ex = sb.pop_front(); checks++;
    if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [7:0] e;
    for (int c = 0; c < 8; c++) begin
      clear_in();
      hif.if_en = 1'b1; hif.id_dst_addr = 5'd5;
      case (c)
        0: begin hif.load_in_id_ex = 1; hif.rs0_used = 1; hif.rs1_used = 1;
                 hif.gpr_rd_addr_0 = 5'd3; hif.gpr_rd_addr_1 = 5'd5; e = S_IF | F_ID; end
        1: e = 8'h00;
        2: begin hif.load_in_id_ex = 1; hif.rs0_used = 1; hif.gpr_rd_addr_0 = 5'd5; e = S_IF | F_ID; end
        3: begin hif.load_in_id_ex = 1; hif.id_dst_addr = 5'd0; hif.rs0_used = 1; hif.rs1_used = 1;
                 hif.gpr_rd_addr_1 = 5'd0; e = 8'h00; end
        4: begin hif.load_in_id_ex = 1; hif.gpr_rd_addr_0 = 5'd5; hif.gpr_rd_addr_1 = 5'd5; e = 8'h00; end
        5: begin hif.load_in_id_ex = 1; hif.if_en = 0; hif.rs1_used = 1; hif.gpr_rd_addr_1 = 5'd5; e = 8'h00; end
        6: begin hif.rs1_used = 1; hif.gpr_rd_addr_1 = 5'd5; e = 8'h00; end
        default: begin hif.load_in_id_ex = 1; hif.rs1_used = 1; hif.gpr_rd_addr_1 = 5'd6; e = 8'h00; end
      endcase
      sb.push_back('{"load_use", c, e});
      @(negedge clk);
      obs = outs(); ex = sb.pop_front(); checks++;
      if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divide();
    logic [7:0] e;
    for (int c = 1; c <= 35; c++) begin
      clear_in();
      if (c == 1)  hif.id_is_div = 1'b1;
      if (c == 35) begin hif.id_is_div = 1'b1; hif.rem_after_div = 1'b1; end
      if (c == 1)       e = STALL | START;
      else if (c <= 32) e = STALL | BUSY;
      else if (c == 33) e = DONE | BUSY;
      else              e = 8'h00;
      sb.push_back('{"divide", c, e});
      @(negedge clk);
      obs = outs(); ex = sb.pop_front(); checks++;
      if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap_in_div();
    logic [7:0] e;
    for (int c = 1; c <= 40; c++) begin
      clear_in();
      if (c == 1)  hif.id_is_div = 1'b1;
      if (c == 11) hif.trap_req = 1'b1;
      if (c == 5)  hif.branch_taken = 1'b1;
      if (c == 12) hif.branch_taken = 1'b1;
      if (c == 1)            e = STALL | START;
      else if (c <= 10)      e = STALL | BUSY;
      else if (c == 11)      e = FLUSH | ABORT | BUSY;
      else if (c <= 13)      e = FLUSH;
      else                   e = 8'h00;
      sb.push_back('{"trap_in_div", c, e});
      @(negedge clk);
      obs = outs(); ex = sb.pop_front(); checks++;
      if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_trap();
    logic [7:0] e;
    for (int c = 1; c <= 10; c++) begin
      clear_in();
      if (c == 1) hif.branch_taken = 1'b1;
      if (c == 3) begin hif.branch_taken = 1'b1; hif.trap_req = 1'b1; end
      if (c == 7) hif.trap_req = 1'b1;
      if (c == 8) hif.trap_req = 1'b1;
      case (c)
        1, 3, 4, 5, 7, 8, 9, 10: e = FLUSH;
        default:                 e = 8'h00;
      endcase
      sb.push_back('{"branch_trap", c, e});
      @(negedge clk);
      obs = outs(); ex = sb.pop_front(); checks++;
      if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
      @(posedge clk); #1;
    end
    clear_in();
    sb.push_back('{"branch_trap_end", 11, 8'h00});
    @(negedge clk);
    obs = outs(); ex = sb.pop_front(); checks++;
    if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_en();
    logic [7:0] e;
    for (int c = 1; c <= 39; c++) begin
      clear_in();
      if (c == 1) hif.id_is_div = 1'b1;
      if (c >= 7 && c <= 11) cpu_en = 1'b0;
      if (c == 1)       e = STALL | START;
      else if (c <= 37) e = STALL | BUSY;
      else if (c == 38) e = DONE | BUSY;
      else              e = 8'h00;
      sb.push_back('{"cpu_en", c, e});
      @(negedge clk);
      obs = outs(); ex = sb.pop_front(); checks++;
      if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    for (int c = 1; c <= 44; c++) begin
      clear_in();
      rst_n = !(c == 6 || c == 42);
      if (c == 1)  hif.id_is_div = 1'b1;
      if (c == 41) hif.trap_req = 1'b1;
      if (c == 1)       e = STALL | START;
      else if (c <= 5)  e = STALL | BUSY;
      else if (c == 41) e = FLUSH;
      else              e = 8'h00;
      sb.push_back('{"reset_mid", c, e});
      @(negedge clk);
      obs = outs(); ex = sb.pop_front(); checks++;
      if (obs !== ex.exp) begin errors++; $display("FAIL %s cyc %0d got %b exp %b", ex.tag, ex.cyc, obs, ex.exp); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_trap_in_div();
    test_branch_trap();
    test_cpu_en();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
